sdram_req_arbiter: RTL

// - Shares the single SDRAM controller request port among NUM_PORTS requesters (e.g. CPU

---
 rtl/sdram_req_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one single-beat SDRAM controller port among NUM_PORTS requesters.
// Optional ack watchdog with DRAIN recovery enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_req_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [NUM_PORTS-1:0]      req_write,
    input  logic [32*NUM_PORTS-1:0]   req_addr,
    input  logic [32*NUM_PORTS-1:0]   req_wdata,
    input  logic [4*NUM_PORTS-1:0]    req_wstrb,
    output logic [NUM_PORTS-1:0]      req_ready,
    output logic [NUM_PORTS-1:0]      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_error,
    output logic [3:0]                core_wr_o,
    output logic                      core_rd_o,
    output logic [7:0]                core_len_o,
    output logic [31:0]               core_addr_o,
    output logic [31:0]               core_wdata_o,
    input  logic                      core_accept_i,
    input  logic                      core_ack_i,
    input  logic                      core_error_i,
    input  logic [31:0]               core_rdata_i
);
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

`ifdef SDRAM_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_DRAIN} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK} state_e;
`endif

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic                   write_q, write_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   core_rd_q, core_rd_d;
    logic [3:0]             core_wr_q, core_wr_d;
    logic [NUM_PORTS-1:0]   req_ready_q, req_ready_d;
    logic [NUM_PORTS-1:0]   resp_valid_q, resp_valid_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic                   resp_error_q, resp_error_d;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand_idx;
    logic                   fin_ack;
    logic                   fin_tmo;

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [15:0]            timer_q, timer_d;
    logic                   timeout_c;
    assign timeout_c = (timer_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic                   unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Round-robin search starting just after the last granted port
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand_idx = IDX_W'((32'(last_q) + k) % NUM_PORTS);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rd_d    = core_rd_q;
        core_wr_d    = core_wr_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        fin_ack      = 1'b0;
        fin_tmo      = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d     = win_idx;
                    write_d     = req_write[win_idx];
                    addr_d      = req_addr[32*win_idx +: 32];
                    wdata_d     = req_wdata[32*win_idx +: 32];
                    core_rd_d   = !req_write[win_idx];
                    core_wr_d   = req_write[win_idx] ? req_wstrb[4*win_idx +: 4] : 4'b0;
                    req_ready_d = NUM_PORTS'(1) << win_idx;
                    state_d     = ST_ISSUE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end
            end
            ST_ISSUE: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                timer_d = timer_q + 16'd1;
`endif
                if (core_accept_i && core_ack_i) begin
                    fin_ack = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (timeout_c) begin
                    fin_tmo = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
                else if (core_accept_i) begin
                    state_d = ST_WAIT_ACK;
                end
                if (core_accept_i || fin_tmo) begin
                    core_rd_d = 1'b0;
                    core_wr_d = 4'b0;
                end
            end
            ST_WAIT_ACK: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
                timer_d = timer_q + 16'd1;
`endif
                if (core_ack_i) begin
                    fin_ack = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (timeout_c) begin
                    fin_tmo = 1'b1;
                    state_d = ST_DRAIN;
                end
`endif
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            // Swallow the late ack of an abandoned transaction
            ST_DRAIN: begin
                if (core_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (fin_ack || fin_tmo) begin
            resp_valid_d = NUM_PORTS'(1) << grant_q;
            last_d       = grant_q;
        end
        if (fin_ack) begin
            resp_rdata_d = write_q ? 32'd0 : core_rdata_i;
            resp_error_d = core_error_i;
        end
        if (fin_tmo) begin
            resp_error_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_q       <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rd_q    <= 1'b0;
            core_wr_q    <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rd_q    <= core_rd_d;
            core_wr_q    <= core_wr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_error   = resp_error_q;
    assign core_rd_o    = core_rd_q;
    assign core_wr_o    = core_wr_q;
    assign core_len_o   = 8'd0;
    assign core_addr_o  = addr_q;
    assign core_wdata_o = wdata_q;

endmodule
